// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants, descriptor type and helpers for the hazard scoreboard
package hazard_pkg;

    localparam int STG_E = 1;
    localparam int STG_M = 2;
    localparam int STG_R = 3;
    localparam int STG_W = 4;

    localparam int FWD_NONE = 0;

    // Descriptor field widths; the scoreboard's RAW/TW parameters must equal these.
    localparam int DESC_RAW = 5;
    localparam int DESC_TW  = 3;

    typedef struct packed {
        logic                valid;
        logic                md_start;
        logic [DESC_RAW-1:0] dst;
        logic [DESC_TW-1:0]  rem;
        logic [DESC_RAW-1:0] rs;
        logic [DESC_RAW-1:0] rt;
    } hz_desc_t;

    function automatic logic [DESC_TW-1:0] sat_dec(input logic [DESC_TW-1:0] v);
        return (v == '0) ? '0 : v - DESC_TW'(1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - D-stage hazard query and stall/forward response bundle
interface hazard_scoreboard_if #(
    parameter int RAW  = 5,
    parameter int TW   = 3,
    parameter int SELW = 3
) ();
    logic [RAW-1:0]  rs_d;
    logic [RAW-1:0]  rt_d;
    logic [TW-1:0]   tuse_rs_d;
    logic [TW-1:0]   tuse_rt_d;
    logic            use_rs_d;
    logic            use_rt_d;
    logic [RAW-1:0]  dst_d;
    logic [TW-1:0]   tnew_d;
    logic            md_d;
    logic            md_start_d;
    logic            md_div_d;
    logic            freeze;
    logic            flush_all;

    logic            stall;
    logic            flush_e;
    logic            md_busy;
    logic [SELW-1:0] fwd_rs_d;
    logic [SELW-1:0] fwd_rt_d;
    logic [SELW-1:0] fwd_rs_e;
    logic [SELW-1:0] fwd_rt_e;
    logic [SELW-1:0] fwd_rt_m;

    modport master (
        output rs_d, rt_d, tuse_rs_d, tuse_rt_d, use_rs_d, use_rt_d, dst_d, tnew_d,
               md_d, md_start_d, md_div_d, freeze, flush_all,
        input  stall, flush_e, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
    );

    modport slave (
        input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, use_rs_d, use_rt_d, dst_d, tnew_d,
               md_d, md_start_d, md_div_d, freeze, flush_all,
        output stall, flush_e, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
    );
endinterface

// File: rtl/hazard_md_timer.sv
// rtl/hazard_md_timer.sv - mult/div busy countdown loaded with the operation latency
module hazard_md_timer #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);
    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight write tracker deciding D stall, E bubble and forward selects
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGE   = STG_W,
    parameter int RAW      = DESC_RAW,
    parameter int TW       = DESC_TW,
    parameter int SELW     = 3,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    hazard_scoreboard_if.slave   hz
);
    if (RAW != DESC_RAW || TW != DESC_TW || (1 << SELW) <= NSTAGE) begin : g_param_check
        $error("hazard_scoreboard: RAW/TW must match hazard_pkg and 2^SELW must exceed NSTAGE");
    end

    typedef hz_desc_t desc_arr_t [1:NSTAGE];

    desc_arr_t       r_desc;
    desc_arr_t       w_next;
    logic [SELW-1:0] w_k_rs_d, w_k_rt_d, w_k_rs_e, w_k_rt_e, w_k_rt_m;
    logic [TW-1:0]   w_rem_rs_d, w_rem_rt_d, w_rem_rs_e, w_rem_rt_e, w_rem_rt_m;
    logic            w_stall_rs, w_stall_rt, w_stall_md, w_stall;
    logic            w_md_busy, w_md_start;

    // Youngest matching producer at stage >= lo wins; k=0 means no producer in flight.
    function automatic void nearest(input desc_arr_t d, input logic [RAW-1:0] s, input int lo,
                                    output logic [SELW-1:0] k, output logic [TW-1:0] rem);
        k   = SELW'(FWD_NONE);
        rem = '0;
        for (int i = NSTAGE; i >= lo; i--) begin
            if (d[i].valid && d[i].dst != '0 && d[i].dst == s) begin
                k   = SELW'(i);
                rem = d[i].rem;
            end
        end
    endfunction

    always_comb begin
        nearest(r_desc, hz.rs_d,           STG_E, w_k_rs_d, w_rem_rs_d);
        nearest(r_desc, hz.rt_d,           STG_E, w_k_rt_d, w_rem_rt_d);
        nearest(r_desc, r_desc[STG_E].rs,  STG_M, w_k_rs_e, w_rem_rs_e);
        nearest(r_desc, r_desc[STG_E].rt,  STG_M, w_k_rt_e, w_rem_rt_e);
        nearest(r_desc, r_desc[STG_M].rt,  STG_R, w_k_rt_m, w_rem_rt_m);
    end

    assign w_stall_rs = hz.use_rs_d && (w_k_rs_d != '0) && (w_rem_rs_d > hz.tuse_rs_d);
    assign w_stall_rt = hz.use_rt_d && (w_k_rt_d != '0) && (w_rem_rt_d > hz.tuse_rt_d);
    assign w_stall_md = hz.md_d && (w_md_busy || (r_desc[STG_E].valid && r_desc[STG_E].md_start));
    assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;

    assign hz.stall    = w_stall;
    assign hz.flush_e  = w_stall && !hz.freeze;
    assign hz.md_busy  = w_md_busy;

    // A producer is only forwardable once its remaining Tnew has reached zero.
    assign hz.fwd_rs_d = (w_rem_rs_d == '0) ? w_k_rs_d : SELW'(FWD_NONE);
    assign hz.fwd_rt_d = (w_rem_rt_d == '0) ? w_k_rt_d : SELW'(FWD_NONE);
    assign hz.fwd_rs_e = (w_rem_rs_e == '0) ? w_k_rs_e : SELW'(FWD_NONE);
    assign hz.fwd_rt_e = (w_rem_rt_e == '0) ? w_k_rt_e : SELW'(FWD_NONE);
    assign hz.fwd_rt_m = (w_rem_rt_m == '0) ? w_k_rt_m : SELW'(FWD_NONE);

    always_comb begin
        w_next[1] = '0;
        if (!w_stall) begin
            w_next[1].valid    = 1'b1;
            w_next[1].md_start = hz.md_start_d;
            w_next[1].dst      = hz.dst_d;
            w_next[1].rem      = sat_dec(hz.tnew_d);
            w_next[1].rs       = hz.rs_d;
            w_next[1].rt       = hz.rt_d;
        end
        for (int k = 2; k <= NSTAGE; k++) begin
            w_next[k]     = r_desc[k-1];
            w_next[k].rem = sat_dec(r_desc[k-1].rem);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || hz.flush_all) begin
            r_desc <= '{default: '0};
        end else if (!hz.freeze) begin
            r_desc <= w_next;
        end
    end

    assign w_md_start = hz.md_start_d && !w_stall && !hz.freeze;

    hazard_md_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_md_start),
        .is_div  (hz.md_div_d),
        .busy    (w_md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed bench against an instruction-queue model
module tb_hazard_scoreboard;
    localparam int NSTAGE   = 4;
    localparam int RAW      = 5;
    localparam int TW       = 3;
    localparam int SELW     = 3;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.RAW(RAW), .TW(TW), .SELW(SELW)) hz_if ();

    hazard_scoreboard #(
        .NSTAGE(NSTAGE), .RAW(RAW), .TW(TW), .SELW(SELW),
        .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz_if.slave)
    );

    // Instructions in flight, youngest first; entry i sits in stage i+1 and has
    // spent i+1 advancing cycles since leaving D.
    typedef struct {
        bit v;
        int dst;
        int rs;
        int rt;
        int tnew;
        bit mds;
    } instr_t;

    instr_t pipe_q[$];
    int     cyc;
    int     md_end;
    int     total = 0;
    int     bad   = 0;
    bit     e_stall;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic instr_t bubble();
        instr_t b;
        b = '{default: 0};
        return b;
    endfunction

    task automatic model_reset();
        pipe_q.delete();
        for (int i = 0; i < NSTAGE; i++) pipe_q.push_back(bubble());
        md_end = 0;
    endtask

    function automatic void near(input int s, input int lo, output int k, output int rem);
        k   = 0;
        rem = 0;
        for (int st = lo; st <= NSTAGE; st++) begin
            if (k == 0 && pipe_q[st-1].v && pipe_q[st-1].dst != 0 && pipe_q[st-1].dst == s) begin
                k   = st;
                rem = (pipe_q[st-1].tnew > st) ? pipe_q[st-1].tnew - st : 0;
            end
        end
    endfunction

    task automatic set_nop();
        hz_if.rs_d = '0;       hz_if.rt_d = '0;
        hz_if.tuse_rs_d = '0;  hz_if.tuse_rt_d = '0;
        hz_if.use_rs_d = 1'b0; hz_if.use_rt_d = 1'b0;
        hz_if.dst_d = '0;      hz_if.tnew_d = '0;
        hz_if.md_d = 1'b0;     hz_if.md_start_d = 1'b0; hz_if.md_div_d = 1'b0;
        hz_if.freeze = 1'b0;   hz_if.flush_all = 1'b0;
    endtask

    task automatic rand_inputs();
        hz_if.rs_d       = RAW'($urandom_range(0, 3));
        hz_if.rt_d       = RAW'($urandom_range(0, 3));
        hz_if.tuse_rs_d  = TW'($urandom_range(0, 3));
        hz_if.tuse_rt_d  = TW'($urandom_range(0, 3));
        hz_if.use_rs_d   = 1'($urandom_range(0, 1));
        hz_if.use_rt_d   = 1'($urandom_range(0, 1));
        hz_if.dst_d      = RAW'($urandom_range(0, 3));
        hz_if.tnew_d     = TW'($urandom_range(0, 5));
        hz_if.md_start_d = ($urandom_range(0, 15) == 0);
        hz_if.md_div_d   = 1'($urandom_range(0, 1));
        hz_if.md_d       = hz_if.md_start_d || ($urandom_range(0, 7) == 0);
        hz_if.freeze     = ($urandom_range(0, 9) == 0);
        hz_if.flush_all  = ($urandom_range(0, 29) == 0);
        reset_n          = ($urandom_range(0, 99) != 0);
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic step();
        int     k, rem;
        bit     srs, srt, smd, busy;
        instr_t n;
        #1;
        near(int'(hz_if.rs_d), 1, k, rem);
        srs = hz_if.use_rs_d && k != 0 && rem > int'(hz_if.tuse_rs_d);
        check_eq("fwd_rs_d", 32'(hz_if.fwd_rs_d), (k != 0 && rem == 0) ? k : 0);
        near(int'(hz_if.rt_d), 1, k, rem);
        srt = hz_if.use_rt_d && k != 0 && rem > int'(hz_if.tuse_rt_d);
        check_eq("fwd_rt_d", 32'(hz_if.fwd_rt_d), (k != 0 && rem == 0) ? k : 0);
        near(pipe_q[0].rs, 2, k, rem);
        check_eq("fwd_rs_e", 32'(hz_if.fwd_rs_e), (k != 0 && rem == 0) ? k : 0);
        near(pipe_q[0].rt, 2, k, rem);
        check_eq("fwd_rt_e", 32'(hz_if.fwd_rt_e), (k != 0 && rem == 0) ? k : 0);
        near(pipe_q[1].rt, 3, k, rem);
        check_eq("fwd_rt_m", 32'(hz_if.fwd_rt_m), (k != 0 && rem == 0) ? k : 0);
        busy    = (cyc < md_end);
        smd     = hz_if.md_d && (busy || (pipe_q[0].v && pipe_q[0].mds));
        e_stall = srs || srt || smd;
        check_eq("stall",   32'(hz_if.stall),   32'(e_stall));
        check_eq("flush_e", 32'(hz_if.flush_e), 32'(e_stall && !hz_if.freeze));
        check_eq("md_busy", 32'(hz_if.md_busy), 32'(busy));

        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            model_reset();
        end else begin
            if (hz_if.md_start_d && !e_stall && !hz_if.freeze)
                md_end = cyc + (hz_if.md_div_d ? DIV_LAT : MULT_LAT);
            if (hz_if.flush_all) begin
                for (int i = 0; i < NSTAGE; i++) pipe_q[i] = bubble();
            end else if (!hz_if.freeze) begin
                n = bubble();
                if (!e_stall) begin
                    n.v    = 1'b1;
                    n.dst  = int'(hz_if.dst_d);
                    n.rs   = int'(hz_if.rs_d);
                    n.rt   = int'(hz_if.rt_d);
                    n.tnew = int'(hz_if.tnew_d);
                    n.mds  = hz_if.md_start_d;
                end
                void'(pipe_q.pop_back());
                pipe_q.push_front(n);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_stall"},   32'(hz_if.stall),    0);
        check_eq({tag, "_flush_e"}, 32'(hz_if.flush_e),  0);
        check_eq({tag, "_md_busy"}, 32'(hz_if.md_busy),  0);
        check_eq({tag, "_fwd_rsd"}, 32'(hz_if.fwd_rs_d), 0);
        check_eq({tag, "_fwd_rtd"}, 32'(hz_if.fwd_rt_d), 0);
        check_eq({tag, "_fwd_rse"}, 32'(hz_if.fwd_rs_e), 0);
        check_eq({tag, "_fwd_rte"}, 32'(hz_if.fwd_rt_e), 0);
        check_eq({tag, "_fwd_rtm"}, 32'(hz_if.fwd_rt_m), 0);
    endtask

    initial begin
        set_nop();
        reset_n = 1'b0;
        cyc     = 0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        #1;
        check_all_zero("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // load then dependent ALU op
        set_nop(); hz_if.dst_d = 5'd2; hz_if.tnew_d = 3'd3; step();
        set_nop(); hz_if.rs_d = 5'd2; hz_if.use_rs_d = 1'b1; hz_if.tuse_rs_d = 3'd1;
        repeat (2) step();
        set_nop(); repeat (4) step();

        // ALU op then branch on its result
        set_nop(); hz_if.dst_d = 5'd3; hz_if.tnew_d = 3'd1; step();
        set_nop(); hz_if.rs_d = 5'd3; hz_if.use_rs_d = 1'b1; step();
        set_nop(); repeat (3) step();

        // two writers of $4, nearest must win
        set_nop(); hz_if.dst_d = 5'd4; hz_if.tnew_d = 3'd1; repeat (2) step();
        set_nop(); hz_if.rt_d = 5'd4; hz_if.use_rt_d = 1'b1; hz_if.tuse_rt_d = 3'd1; step();
        set_nop(); repeat (4) step();

        // mult then mfhi, div then mfhi
        for (int d = 0; d < 2; d++) begin
            set_nop(); hz_if.md_d = 1'b1; hz_if.md_start_d = 1'b1; hz_if.md_div_d = 1'(d); step();
            set_nop(); hz_if.md_d = 1'b1; repeat (DIV_LAT + 3) step();
        end

        // freeze during a pending load with the MD timer running
        set_nop(); hz_if.md_d = 1'b1; hz_if.md_start_d = 1'b1; step();
        set_nop(); hz_if.dst_d = 5'd2; hz_if.tnew_d = 3'd4; step();
        set_nop(); hz_if.rs_d = 5'd2; hz_if.use_rs_d = 1'b1; hz_if.tuse_rs_d = 3'd1; step();
        hz_if.freeze = 1'b1; repeat (3) step();
        hz_if.freeze = 1'b0; repeat (4) step();

        // reset in the middle of a divide with every stage occupied
        set_nop(); hz_if.md_d = 1'b1; hz_if.md_start_d = 1'b1; hz_if.md_div_d = 1'b1; step();
        for (int i = 1; i <= NSTAGE; i++) begin
            set_nop(); hz_if.dst_d = RAW'(i); hz_if.tnew_d = 3'd0; hz_if.rs_d = RAW'(i); step();
        end
        reset_n = 1'b0; step();
        reset_n = 1'b1;
        set_nop(); hz_if.md_d = 1'b1; hz_if.rs_d = 5'd1; hz_if.use_rs_d = 1'b1;
        #1;
        check_all_zero("rst_mid");
        step();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
